seq_mult8: RTL and testbench

- 8x8 unsigned shift-and-add multiplier controller sitting directly upstream and downstream of the team's 8-bit carry-skip adder.
- Drives the adder's operand and carry-in inputs every cycle and consumes its 8-bit sum.
- Reconstructs the adder's carry-out locally, because the adder exports no carry-out port.
- Valid/ready handshake on both sides; one multiplication in flight at a time.

---
 rtl/seq_mult8.sv | 102 ++++++++++
 tb/tb_seq_mult8.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seq_mult8.sv
// seq_mult8: 8x8 unsigned shift-and-add multiplier controller.
// The add itself is done by an external 8-bit adder (operands out, sum back in).
// That adder has no carry-out port, so the carry is rebuilt here from the
// operand and sum MSBs and shifted into the top of the partial product.
module seq_mult8 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_sum,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] hi, lo, m;
    logic [CNT_W-1:0] cnt;
    logic             cout;
    logic             last_iter;

    assign last_iter = (cnt == {CNT_W{1'b1}});

    // MSB of a+b+0 is lost by the adder; recover it from the top bits:
    // both set -> carry; exactly one set -> carry only if sum MSB dropped to 0.
    assign cout = (add_a[WIDTH-1] & add_b[WIDTH-1])
                | ((add_a[WIDTH-1] ^ add_b[WIDTH-1]) & ~add_sum[WIDTH-1]);

    // Result is always taken straight from the shift registers.
    assign product = {hi, lo};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last_iter) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // Handshake and adder drive; adder inputs parked at 0 outside RUN
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            RUN: begin
                add_a = hi;
                add_b = lo[0] ? m : '0;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: load on accept, then one 17-bit right shift {cout,sum,lo} per cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi  <= '0;
            lo  <= '0;
            m   <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    m   <= mcand;
                    lo  <= mplier;
                    hi  <= '0;
                    cnt <= '0;
                end
                RUN: begin
                    hi  <= {cout, add_sum[WIDTH-1:1]};
                    lo  <= {add_sum[0], lo[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult8.sv
// tb_seq_mult8: directed + random check of seq_mult8 against a carry-skip
// adder model and a plain-arithmetic product/handshake reference.
module tb_seq_mult8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  mcand, mplier;
    logic [7:0]  add_a, add_b, add_sum;
    logic        add_cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;

    int nchk  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    // 8-bit carry-skip adder: two 4-bit ripple blocks, block carry bypassed
    // when every bit in the block propagates.
    function automatic logic [7:0] csa8(input logic [7:0] a, input logic [7:0] b, input logic c0);
        logic [7:0] s;
        logic       c, rc, p;
        int         j;
        s = '0;
        c = c0;
        for (int blk = 0; blk < 2; blk++) begin
            rc = c;
            p  = 1'b1;
            for (int k = 0; k < 4; k++) begin
                j    = blk * 4 + k;
                s[j] = a[j] ^ b[j] ^ rc;
                rc   = (a[j] & b[j]) | ((a[j] ^ b[j]) & rc);
                p    = p & (a[j] ^ b[j]);
            end
            c = p ? c : rc;
        end
        return s;
    endfunction

    assign add_sum = csa8(add_a, add_b, add_cin);

    seq_mult8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mcand     (mcand),
        .mplier    (mplier),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // One full operation: accept, 8 RUN cycles, DONE held for 'hold' cycles
    // with operand pokes, then handshake. Returns number of carries seen.
    task automatic op(input logic [7:0] mc, input logic [7:0] mp, input int hold, output int ncy);
        logic [8:0]  s9;
        logic [15:0] exp;
        exp = 16'(mc) * 16'(mp);
        ncy = 0;
        s9  = '0;
        @(negedge clk);
        chk("idle_rdy", in_ready, 1);
        in_valid = 1'b1; mcand = mc; mplier = mp;
        @(negedge clk);
        in_valid = 1'b0; mcand = 8'($urandom); mplier = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                chk("cout", product[15], s9[8]);
                ncy += int'(s9[8]);
            end
            chk("run_vld", out_valid, 0);
            chk("run_rdy", in_ready, 0);
            chk("add_b", add_b, mp[i] ? mc : 8'h00);
            chk("add_cin", add_cin, 0);
            s9 = {1'b0, add_a} + {1'b0, add_b};
            in_valid = (i == 3);
            @(negedge clk);
            in_valid = 1'b0;
        end
        chk("cout", product[15], s9[8]);
        ncy += int'(s9[8]);
        chk("done_vld", out_valid, 1);
        chk("product", product, exp);
        chk("done_add", {add_a, add_b, 7'b0, add_cin}, 0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; mcand = 8'($urandom); mplier = 8'($urandom);
            @(negedge clk);
            chk("hold_vld", out_valid, 1);
            chk("hold_rdy", in_ready, 0);
            chk("hold_prod", product, exp);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_vld", out_valid, 0);
        chk("post_rdy", in_ready, 1);
        chk("post_prod", product, exp);
    endtask

    initial begin
        int          ncy, cyc, lat, ndone;
        bit          pending;
        logic [15:0] q[$];
        logic [15:0] e;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mcand = '0; mplier = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_rdy", in_ready, 1);
        chk("rst_vld", out_valid, 0);
        chk("rst_prod", product, 0);
        chk("rst_add", {add_a, add_b, 7'b0, add_cin}, 0);

        op(8'd13, 8'd11, 0, ncy);
        op(8'hFF, 8'hFF, 0, ncy);
        chk("ff_carries", ncy, 7);
        op(8'h00, 8'hA5, 0, ncy);
        op(8'h01, 8'hA5, 0, ncy);
        op(8'h80, 8'h02, 0, ncy);
        op(8'd7, 8'd9, 5, ncy);

        // Reset while RUN with cnt==4 (four RUN edges after acceptance)
        @(negedge clk);
        in_valid = 1'b1; mcand = 8'h5A; mplier = 8'h3C;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rdy", in_ready, 1);
        chk("mid_vld", out_valid, 0);
        chk("mid_prod", product, 0);
        chk("mid_add", {add_a, add_b, 7'b0, add_cin}, 0);
        op(8'd3, 8'd5, 0, ncy);

        // Back-to-back random: in_valid always high, random backpressure.
        pending = 1'b0; lat = 0; ndone = 0; cyc = 0;
        while (ndone < 200 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            chk("rnd_rdy", in_ready, !pending);
            chk("rnd_vld", out_valid, pending && lat >= 8);
            in_valid  = 1'b1;
            mcand     = 8'($urandom);
            mplier    = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            if (pending) lat++;
            if (out_valid && out_ready) begin
                e = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
                chk("rnd_prod", product, e);
                pending = 1'b0;
                ndone++;
            end
            if (in_valid && in_ready) begin
                q.push_back(16'(mcand) * 16'(mplier));
                pending = 1'b1;
                lat = 0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("rnd_count", ndone, 200);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

endmodule
